// File: rtl/nrisc_boot_loader.sv
// Boot loader for the nRisc core: parses a length-prefixed byte stream into the
// instruction and data memories, verifies an XOR checksum, then releases the core.
`timescale 1ns/1ps
module nrisc_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              IN_VALID,
  input  logic [7:0]        IN_DATA,
  output logic              IN_READY,
  output logic              IM_WE,
  output logic [ADDR_W-1:0] IM_ADDR,
  output logic [7:0]        IM_DATA,
  output logic              DM_WE,
  output logic [ADDR_W-1:0] DM_ADDR,
  output logic [7:0]        DM_DATA,
  output logic              CPU_RESET,
  output logic              BUSY,
  output logic              ERR
);

  // state     | meaning
  // S_IDLE    | waiting for first START, core held in reset
  // S_I_LEN   | expecting instruction length byte
  // S_I_BYTES | writing instruction bytes to IM
  // S_D_LEN   | expecting data length byte
  // S_D_BYTES | writing data bytes to DM
  // S_CHECK   | expecting checksum byte
  // S_DONE    | load good, core released
  // S_ERROR   | checksum mismatch, core held in reset
  typedef enum logic [2:0] {
    S_IDLE,
    S_I_LEN,
    S_I_BYTES,
    S_D_LEN,
    S_D_BYTES,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        xor_q, xor_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [7:0]        im_data_q, im_data_d;
  logic              dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [7:0]        dm_data_q, dm_data_d;
  logic              in_ready;
  logic              accept;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      xor_q     <= '0;
      im_we_q   <= 1'b0;
      im_addr_q <= '0;
      im_data_q <= '0;
      dm_we_q   <= 1'b0;
      dm_addr_q <= '0;
      dm_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      xor_q     <= xor_d;
      im_we_q   <= im_we_d;
      im_addr_q <= im_addr_d;
      im_data_q <= im_data_d;
      dm_we_q   <= dm_we_d;
      dm_addr_q <= dm_addr_d;
      dm_data_q <= dm_data_d;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_I_LEN, S_I_BYTES, S_D_LEN, S_D_BYTES, S_CHECK: in_ready = 1'b1;
      default:                                          in_ready = 1'b0;
    endcase
  end

  assign accept = IN_VALID & in_ready;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = addr_q;
    xor_d     = xor_q;
    im_we_d   = 1'b0;
    im_addr_d = im_addr_q;
    im_data_d = im_data_q;
    dm_we_d   = 1'b0;
    dm_addr_d = dm_addr_q;
    dm_data_d = dm_data_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (START) begin
          state_d = S_I_LEN;
          len_d   = '0;
          addr_d  = '0;
          xor_d   = '0;
        end
      end
      S_I_LEN: begin
        if (accept) begin
          xor_d   = xor_q ^ IN_DATA;
          len_d   = IN_DATA;
          addr_d  = '0;
          state_d = (IN_DATA != 8'd0) ? S_I_BYTES : S_D_LEN;
        end
      end
      S_I_BYTES: begin
        if (accept) begin
          xor_d     = xor_q ^ IN_DATA;
          im_we_d   = 1'b1;
          im_addr_d = addr_q;
          im_data_d = IN_DATA;
          addr_d    = addr_q + 1'b1;
          len_d     = len_q - 8'd1;
          if (len_q == 8'd1) state_d = S_D_LEN;
        end
      end
      S_D_LEN: begin
        if (accept) begin
          xor_d   = xor_q ^ IN_DATA;
          len_d   = IN_DATA;
          addr_d  = '0;
          state_d = (IN_DATA != 8'd0) ? S_D_BYTES : S_CHECK;
        end
      end
      S_D_BYTES: begin
        if (accept) begin
          xor_d     = xor_q ^ IN_DATA;
          dm_we_d   = 1'b1;
          dm_addr_d = addr_q;
          dm_data_d = IN_DATA;
          addr_d    = addr_q + 1'b1;
          len_d     = len_q - 8'd1;
          if (len_q == 8'd1) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // checksum byte itself is not folded into the running XOR
        if (accept) state_d = (IN_DATA == xor_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign IN_READY  = in_ready;
  assign IM_WE     = im_we_q;
  assign IM_ADDR   = im_addr_q;
  assign IM_DATA   = im_data_q;
  assign DM_WE     = dm_we_q;
  assign DM_ADDR   = dm_addr_q;
  assign DM_DATA   = dm_data_q;
  assign CPU_RESET = (state_q != S_DONE);
  assign BUSY      = in_ready;
  assign ERR       = (state_q == S_ERROR);

endmodule

// File: doc/nrisc_boot_loader.md
NRISC_BOOT_LOADER -- requirements
Module: nrisc_boot_loader

Interface
REQ-001 Parameter: ADDR_W, default 8, address width of the instruction and data memory write ports.
REQ-002 CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 START  input  1  single-cycle request to begin a load; sampled in IDLE, DONE and ERROR only.
REQ-005 IN_VALID  input  1  byte-stream valid.
REQ-006 IN_DATA  input  8  byte-stream data.
REQ-007 IN_READY  output  1  loader can accept a byte; a byte transfers when IN_VALID and IN_READY are both high.
REQ-008 IM_WE  output  1  instruction memory write strobe.
REQ-009 IM_ADDR  output  ADDR_W  instruction memory write address.
REQ-010 IM_DATA  output  8  instruction memory write data.
REQ-011 DM_WE / DM_ADDR / DM_DATA  output  1 / ADDR_W / 8  data memory write port, same semantics as the IM port.
REQ-012 CPU_RESET  output  1  reset to the nRisc core; high holds the core in reset.
REQ-013 BUSY  output  1  load in progress.
REQ-014 ERR  output  1  last load failed its checksum.

Function
REQ-015 Stream format: I_LEN byte, I_LEN instruction bytes, D_LEN byte, D_LEN data bytes, CHK byte.
REQ-016 States: IDLE, I_LEN, I_BYTES, D_LEN, D_BYTES, CHECK, DONE, ERROR.
REQ-017 IDLE: IN_READY=0; START -> I_LEN.
REQ-018 I_LEN: accepted byte loads the length counter; nonzero -> I_BYTES, zero -> D_LEN.
REQ-019 I_BYTES: each accepted byte is written to the IM at address 0,1,2,... in order; after the I_LEN-th byte -> D_LEN.
REQ-020 D_LEN / D_BYTES: same as REQ-018/019 on the DM port; after the last byte (or zero length) -> CHECK.
REQ-021 CHECK: accepted byte is compared with the running XOR of every byte accepted since START (both length bytes included); equal -> DONE, unequal -> ERROR.
REQ-022 IN_READY=1 in I_LEN, I_BYTES, D_LEN, D_BYTES and CHECK; 0 in IDLE, DONE and ERROR.
REQ-023 IM_WE/DM_WE are registered: asserted for exactly one cycle, the cycle after the accepting edge, with the matching address and data; otherwise 0.
REQ-024 At most one IM or DM write per cycle; back-to-back bytes give back-to-back write strobes with no bubble.
REQ-025 Cycles with IN_VALID=0 leave state, counters and the XOR unchanged.
REQ-026 Address counter is ADDR_W bits and is not checked against any limit; a length of 255 writes addresses 0..254.
REQ-027 CPU_RESET=1 in every state except DONE; it falls on the edge that enters DONE.
REQ-028 BUSY=1 in I_LEN through CHECK; ERR=1 only in ERROR.
REQ-029 START in DONE or ERROR: -> I_LEN, clear the XOR and counters, reassert CPU_RESET on the same edge.
REQ-030 START in any other state is ignored.

Reset
REQ-031 RESET=1 at a rising edge: state IDLE, counters and XOR 0, IN_READY=0, IM_WE=DM_WE=0, addresses and data 0, CPU_RESET=1, BUSY=0, ERR=0.
REQ-032 RESET has priority over START and byte acceptance, and aborts a load mid-stream; a write strobe that would have pulsed on the next cycle is suppressed.

Verification
REQ-033 Nominal load: START; stream 02,88,91,01,05,1F -> IM[0]=88 and IM[1]=91; DM[0]=05; DONE; CPU_RESET=0; ERR=0.
REQ-034 Bad checksum: same stream with CHK=1E -> ERROR; ERR=1; CPU_RESET stays 1; IN_READY=0; the memories still hold the written bytes.
REQ-035 Zero lengths: stream 00,00,00 -> DONE with no IM_WE or DM_WE pulse.
REQ-036 Throttling: random IN_VALID gaps during REQ-033 -> identical writes and final state; no strobe during gap cycles.
REQ-037 Reset mid-load: RESET after the 3rd accepted byte -> IDLE next cycle and no further strobes; a later clean START plus the REQ-033 stream succeeds.
REQ-038 Reload: START in DONE -> CPU_RESET=1 on the same edge; a second stream 01,00,00,01 writes IM[0]=00 and reaches DONE.
